// File: rtl/ram_pkg.sv
// ram_pkg: shared types and default sizes for the ram_clr data memory.
//   ram_state_t : clear-sequencer state (ST_CLEAR, ST_READY)
//   RAM_DW      : default data width
//   RAM_DEPTH   : default number of words
//   RAM_AW      : default address width
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  localparam int RAM_DW    = 16;
  localparam int RAM_DEPTH = 10;
  localparam int RAM_AW    = 6;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: FSM and word counter that walk the array writing zeros after
// reset and whenever a clear is requested.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (forces ST_CLEAR, cnt=0)
//   clr      in   request a (re)start of the clear sequence
//   busy     out  clear in progress (state == ST_CLEAR)
//   clr_we   out  clear write enable into the array
//   clr_addr out  word currently being cleared
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = RAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ram_state_t    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        // A clear request while clearing restarts the walk from word 0.
        if (clr) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_reg;

endmodule

// File: rtl/ram_clr.sv
// ram_clr: parametrised single-port data memory with a hardware clear
// sequencer and rejected-write flag.
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (array contents are not reset)
//   clr   in   request a full clear sequence
//   we    in   write enable
//   a     in   word address (unsigned, AW bits)
//   di    in   write data
//   dout  out  read data (0 while busy or when a >= DEPTH)
//   busy  out  clear sequence in progress; accesses are ignored
//   err   out  one-cycle pulse: the previous cycle's write was rejected
// Build option: RAM_SYNC_READ_EN registers dout (1-cycle latency, write-first);
// left undefined, the read path is combinational.
module ram_clr
  import ram_pkg::*;
#(
  parameter int DW    = RAM_DW,
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = RAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] di,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          err
);

  // Index width actually needed to address DEPTH words.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] ram [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          in_range;
  logic          user_wr;
  logic          err_next;
  logic          ram_we;
  logic [IW-1:0] ram_waddr;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] ram_wdata;
  logic          err_reg;
  logic          unused_bits;

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Extra bit so DEPTH == 2**AW still compares correctly.
  assign in_range = ({1'b0, a} < (AW + 1)'(DEPTH));

  // A user write lands only in READY, without a competing clear, in range.
  assign user_wr  = we & ~busy & ~clr & in_range;
  assign err_next = we & (busy | clr | ~in_range);

  // Clear port has priority; while it is active user writes are blocked anyway.
  assign ram_we    = clr_we | user_wr;
  assign ram_waddr = clr_we ? clr_addr[IW-1:0] : a[IW-1:0];
  assign ram_wdata = clr_we ? '0 : di;
  assign rd_idx    = a[IW-1:0];

  // Upper address bits beyond IW are only needed for the range check.
  assign unused_bits = ^{clr_addr, a};

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;

`ifdef RAM_SYNC_READ_EN
  logic [DW-1:0] dout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (busy || !in_range) begin
      dout_reg <= '0;
    end else if (user_wr) begin
      // Write-first: a same-cycle write to the read address returns new data.
      dout_reg <= di;
    end else begin
      dout_reg <= ram[rd_idx];
    end
  end

  assign dout = dout_reg;
`else
  assign dout = (!busy && in_range) ? ram[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_ram_clr.sv
module tb_ram_clr;
  import ram_pkg::*;

  localparam int DW    = RAM_DW;
  localparam int DEPTH = RAM_DEPTH;
  localparam int AW    = RAM_AW;
`ifdef RAM_SYNC_READ_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] di = '0;
  logic [DW-1:0] dout;
  logic          busy;
  logic          err;

  int checks = 0;
  int failures = 0;

  // Reference model: word contents, remaining clear cycles, expected flags.
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left = DEPTH;
  logic          err_m = 1'b0;
  logic [DW-1:0] dout_q_m = '0;

  always #5 clk = ~clk;

  ram_clr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (we),
    .a     (a),
    .di    (di),
    .dout  (dout),
    .busy  (busy),
    .err   (err)
  );

  function automatic logic [DW-1:0] exp_dout();
    if (SYNC) return dout_q_m;
    if (busy_left > 0 || int'(a) >= DEPTH) return '0;
    return mem_m[int'(a)];
  endfunction

  task automatic model_reset();
    busy_left = DEPTH;
    err_m     = 1'b0;
    dout_q_m  = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // One clock edge: predict from the pre-edge inputs, step, update model.
  // Inputs are changed only at negedge; outputs are checked at negedge.
  task automatic cycle();
    logic [DW-1:0] nq;
    logic          ne;
    bit            inr;
    inr = int'(a) < DEPTH;
    ne  = we && (busy_left > 0 || clr || !inr);
    if (busy_left > 0 || !inr) nq = '0;
    else if (we && !clr)       nq = di;
    else                       nq = mem_m[int'(a)];
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      err_m    = ne;
      dout_q_m = nq;
      if (clr) begin
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (we && inr) begin
        mem_m[int'(a)] = di;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    rst_n = 1'b0;
    idle();
    cycle();
    cycle();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b err=%b dout=%h required busy=1 err=0 dout=0000", busy, err, dout);
    end
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      cycle();
      n++;
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL reset_err_quiet err=%b required 0", err);
      end
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL reset_clear_len cycles=%0d required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      cycle();
      checks++;
      if (dout !== '0 || dout !== exp_dout()) begin
        failures++;
        $display("FAIL reset_word_zero a=%0d dout=%h required 0000", i, dout);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; a = AW'(3); di = 16'hBEEF;
    cycle();
    we = 1'b0;
    checks++;
    if (dout !== 16'hBEEF || dout !== exp_dout()) begin
      failures++;
      $display("FAIL write_first_read dout=%h required beef", dout);
    end
    cycle();
    checks++;
    if (dout !== 16'hBEEF || err !== 1'b0) begin
      failures++;
      $display("FAIL write_read_back dout=%h err=%b required beef err=0", dout, err);
    end
  endtask

  task automatic test_out_of_range();
    we = 1'b1; a = AW'(12); di = 16'h1234;
    cycle();
    we = 1'b0;
    checks++;
    if (err !== 1'b1 || dout !== '0) begin
      failures++;
      $display("FAIL oor_write err=%b dout=%h required err=1 dout=0000", err, dout);
    end
    a = AW'(2);
    cycle();
    checks++;
    if (err !== 1'b0 || dout !== 16'h0000 || dout !== exp_dout()) begin
      failures++;
      $display("FAIL oor_no_change err=%b dout=%h required err=0 dout=0000", err, dout);
    end
    a = AW'(12);
    cycle();
    checks++;
    if (err !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL oor_read err=%b dout=%h required err=0 dout=0000", err, dout);
    end
  endtask

  task automatic test_clr_with_write();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; a = AW'(i); di = DW'(16'h0100 + i);
      cycle();
    end
    we = 1'b0; a = AW'(7);
    cycle();
    checks++;
    if (dout !== 16'h0107 || dout !== exp_dout()) begin
      failures++;
      $display("FAIL fill_read a=7 dout=%h required 0107", dout);
    end
    clr = 1'b1; we = 1'b1; a = AW'(5); di = 16'hFFFF;
    cycle();
    idle();
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_we_err err=%b busy=%b required err=1 busy=1", err, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL clr_len cycles=%0d required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(i);
      cycle();
      checks++;
      if (dout !== '0 || dout !== exp_dout()) begin
        failures++;
        $display("FAIL clr_word_zero a=%0d dout=%h required 0000", i, dout);
      end
    end
  endtask

  task automatic test_clr_restart();
    int n;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0; we = 1'b1; a = AW'(1); di = 16'hAAAA;
    cycle();
    we = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_write_err err=%b busy=%b required err=1 busy=1", err, busy);
    end
    n = 1;
    while (busy === 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL restart_len cycles=%0d required %0d", n, DEPTH);
    end
    cycle();
    checks++;
    if (dout !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL busy_write_dropped dout=%h err=%b required 0000 err=0", dout, err);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    we = 1'b1; a = AW'(4); di = 16'h5A5A;
    cycle();
    we = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy !== 1'b1 || dout !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_clear busy=%b dout=%h err=%b required busy=1 dout=0000 err=0", busy, dout, err);
    end
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL rst_clear_len cycles=%0d required %0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 1) == 1);
      a   = AW'($urandom_range(0, DEPTH + 3));
      di  = DW'($urandom);
      cycle();
      checks++;
      if (err !== err_m || busy !== (busy_left > 0) || dout !== exp_dout()) begin
        failures++;
        $display("FAIL random i=%0d err=%b busy=%b dout=%h required err=%b busy=%b dout=%h",
                 i, err, busy, dout, err_m, (busy_left > 0), exp_dout());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_clr_with_write();
    test_clr_restart();
    test_reset_mid_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
